mme_ctrl: RTL and testbench

Sequencing controller inside the matrix-multiply engine (MME). Takes latched APB configuration (matrix width, A/B/C base addresses) and a start command. Fetches A columns and B rows over the AXI read channels in 4-beat chunks and steps the 4x4 MAC array. After the array drains, writes the 4x4 C result over the AXI write channels and raises a sticky done status.

---
 rtl/mme_ctrl.sv | 158 +++++++++++++++
 tb/tb_mme_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mme_ctrl.sv
// rtl/mme_ctrl.sv - MME sequencing controller: operand fetch, MAC stepping, C write-back
module mme_ctrl #(
    parameter int PIPE_DEPTH = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [7:0]        mat_width_i,
    input  logic [ADDR_W-1:0] mat_a_addr_i,
    input  logic [ADDR_W-1:0] mat_b_addr_i,
    input  logic [ADDR_W-1:0] mat_c_addr_i,
    output logic              done_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic [7:0]        arlen_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    output logic              buf_wr_a_o,
    output logic              buf_wr_b_o,
    output logic [1:0]        buf_idx_o,
    output logic              acc_clr_o,
    output logic              mac_en_o,
    output logic [1:0]        mac_k_o,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic [7:0]        awlen_o,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic              wvalid_o,
    input  logic              wready_i,
    output logic              wlast_o,
    output logic [1:0]        wrow_o,
    input  logic              bvalid_i,
    output logic              bready_o
);

    localparam int DW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

    typedef enum logic [3:0] {
        IDLE, AR_A, R_A, AR_B, R_B, MAC, DRAIN, AW, W, BWAIT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_cnt;       // shared beat / MAC-step / W-row counter
    logic [5:0]        r_j;         // current chunk index
    logic [5:0]        r_n;         // chunk count latched at start
    logic [DW-1:0]     r_drain;
    logic [ADDR_W-1:0] r_a;
    logic [ADDR_W-1:0] r_b;
    logic [ADDR_W-1:0] r_c;
    logic              r_done;
    logic              r_acc_clr;

    logic [5:0]        w_n;
    logic [5:0]        w_j_inc;
    logic [ADDR_W-1:0] w_off;

    // Width is floored to whole 4-element chunks by dropping the low two bits
    assign w_n     = 6'(mat_width_i >> 2);
    assign w_j_inc = r_j + 6'd1;
    // Each chunk is 4 beats of 16 bytes, so chunk j starts at byte offset j*64
    assign w_off   = ADDR_W'({r_j, 6'b0});

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode; every phase waits on its own handshake so stalls add cycles one-for-one
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (start_i) w_next = (w_n == 6'd0) ? DRAIN : AR_A;
            AR_A:  if (arready_i) w_next = R_A;
            R_A:   if (rvalid_i && r_cnt == 2'd3) w_next = AR_B;
            AR_B:  if (arready_i) w_next = R_B;
            R_B:   if (rvalid_i && r_cnt == 2'd3) w_next = MAC;
            MAC:   if (r_cnt == 2'd3) w_next = (w_j_inc < r_n) ? AR_A : DRAIN;
            DRAIN: if (r_drain == DW'(PIPE_DEPTH - 1)) w_next = AW;
            AW:    if (awready_i) w_next = W;
            W:     if (wready_i && r_cnt == 2'd3) w_next = BWAIT;
            BWAIT: if (bvalid_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Config latch, counters, sticky done and the one-shot accumulator clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_j       <= '0;
            r_n       <= '0;
            r_drain   <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_done    <= 1'b0;
            r_acc_clr <= 1'b0;
        end else begin
            r_acc_clr <= 1'b0;
            r_drain   <= (r_state == DRAIN) ? r_drain + DW'(1) : '0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_a       <= mat_a_addr_i;
                        r_b       <= mat_b_addr_i;
                        r_c       <= mat_c_addr_i;
                        r_n       <= w_n;
                        r_j       <= '0;
                        r_cnt     <= '0;
                        r_done    <= 1'b0;
                        r_acc_clr <= 1'b1;
                    end
                end
                R_A, R_B: if (rvalid_i) r_cnt <= r_cnt + 2'd1;
                MAC: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) r_j <= w_j_inc;
                end
                W:     if (wready_i) r_cnt <= r_cnt + 2'd1;
                BWAIT: if (bvalid_i) r_done <= 1'b1;
                default: ;
            endcase
        end
    end

    assign done_o     = r_done;
    assign busy_o     = (r_state != IDLE);
    assign acc_clr_o  = r_acc_clr;

    assign arvalid_o  = (r_state == AR_A) || (r_state == AR_B);
    assign araddr_o   = (r_state == AR_A) ? r_a + w_off :
                        (r_state == AR_B) ? r_b + w_off : '0;
    assign arlen_o    = arvalid_o ? 8'd3 : 8'd0;

    assign rready_o   = (r_state == R_A) || (r_state == R_B);
    assign buf_wr_a_o = rvalid_i && (r_state == R_A);
    assign buf_wr_b_o = rvalid_i && (r_state == R_B);
    assign buf_idx_o  = rready_o ? r_cnt : 2'd0;

    assign mac_en_o   = (r_state == MAC);
    assign mac_k_o    = mac_en_o ? r_cnt : 2'd0;

    assign awvalid_o  = (r_state == AW);
    assign awaddr_o   = awvalid_o ? r_c : '0;
    assign awlen_o    = awvalid_o ? 8'd3 : 8'd0;

    assign wvalid_o   = (r_state == W);
    assign wrow_o     = wvalid_o ? r_cnt : 2'd0;
    assign wlast_o    = wvalid_o && (r_cnt == 2'd3);

    assign bready_o   = (r_state == BWAIT);

endmodule

// File: tb/tb_mme_ctrl.sv
// tb/tb_mme_ctrl.sv - directed bench for mme_ctrl
module tb_mme_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [7:0]  mat_width_i;
    logic [31:0] mat_a_addr_i, mat_b_addr_i, mat_c_addr_i;
    logic        done_o, busy_o;
    logic [31:0] araddr_o;
    logic [7:0]  arlen_o;
    logic        arvalid_o, arready_i, rvalid_i, rready_o;
    logic        buf_wr_a_o, buf_wr_b_o;
    logic [1:0]  buf_idx_o;
    logic        acc_clr_o, mac_en_o;
    logic [1:0]  mac_k_o;
    logic [31:0] awaddr_o;
    logic [7:0]  awlen_o;
    logic        awvalid_o, awready_i, wvalid_o, wready_i, wlast_o;
    logic [1:0]  wrow_o;
    logic        bvalid_i, bready_o;

    always #5 clk = ~clk;

    mme_ctrl #(.PIPE_DEPTH(4), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .mat_width_i(mat_width_i),
        .mat_a_addr_i(mat_a_addr_i), .mat_b_addr_i(mat_b_addr_i), .mat_c_addr_i(mat_c_addr_i),
        .done_o(done_o), .busy_o(busy_o),
        .araddr_o(araddr_o), .arlen_o(arlen_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rvalid_i(rvalid_i), .rready_o(rready_o),
        .buf_wr_a_o(buf_wr_a_o), .buf_wr_b_o(buf_wr_b_o), .buf_idx_o(buf_idx_o),
        .acc_clr_o(acc_clr_o), .mac_en_o(mac_en_o), .mac_k_o(mac_k_o),
        .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wvalid_o(wvalid_o), .wready_i(wready_i), .wlast_o(wlast_o), .wrow_o(wrow_o),
        .bvalid_i(bvalid_i), .bready_o(bready_o)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {done_o, busy_o, araddr_o, arlen_o, arvalid_o, rready_o, buf_wr_a_o,
                buf_wr_b_o, buf_idx_o, acc_clr_o, mac_en_o, mac_k_o, awaddr_o, awlen_o,
                awvalid_o, wvalid_o, wlast_o, wrow_o, bready_o};
    endfunction

    // Per-run observations
    logic [31:0] ar_q[$];
    int          done_cyc, mac_cnt, wa_cnt, wb_cnt, w_cnt, aw_cnt, acc_cnt;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    bit          k_ok, w_ok, idx_ok, len_ok, stable_ok, done_c1;
    logic [2:0]  c1_flags;

    // One run with A=0, B=0x1000, C=0x2000 and a driver-side slave.
    // ar_stall: cycles arready is held low on the first AR; tog: rvalid alternates;
    // poke: start and new config applied at cycle 3; rst_at: pull rst_n low in that cycle.
    task automatic run(input logic [7:0] w, input int ar_stall, input bit tog,
                       input bit poke, input int rst_at);
        logic [31:0] prev_addr;
        bit          prev_stalled;
        int          ar_left;
        ar_q.delete();
        done_cyc = -1; mac_cnt = 0; wa_cnt = 0; wb_cnt = 0; w_cnt = 0; aw_cnt = 0; acc_cnt = 0;
        aw_addr = '0; aw_len = '0;
        k_ok = 1; w_ok = 1; idx_ok = 1; len_ok = 1; stable_ok = 1; done_c1 = 0; c1_flags = '0;
        prev_stalled = 0; prev_addr = '0; ar_left = ar_stall;
        @(negedge clk);
        mat_width_i = w; mat_a_addr_i = 32'h0; mat_b_addr_i = 32'h1000; mat_c_addr_i = 32'h2000;
        start_i = 1'b1;
        for (int cyc = 1; cyc < 400; cyc++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (rst_at != 0 && cyc == rst_at + 1) begin
                check_val("rst_mid_outs", all_outs(), '0);
                rst_n = 1'b1;
                return;
            end
            if (rst_at != 0 && cyc == rst_at) begin
                check_val("in_r_b", {1'b0, rready_o, buf_wr_a_o}, 3'b010);
                rst_n = 1'b0;
            end
            if (poke && cyc == 3) begin
                start_i = 1'b1;
                mat_width_i = 8'd16;
                mat_a_addr_i = 32'h5000; mat_b_addr_i = 32'h6000; mat_c_addr_i = 32'h7000;
            end
            if (cyc == 1) begin
                c1_flags = {busy_o, arvalid_o, acc_clr_o};
                done_c1  = done_o;
            end
            if (done_o) begin
                done_cyc = cyc;
                break;
            end
            arready_i = 1'b1;
            if (arvalid_o && ar_left > 0) begin
                arready_i = 1'b0;
                ar_left--;
            end
            rvalid_i = tog ? (cyc % 2 == 1) : 1'b1;
            #1;
            if (prev_stalled && (!arvalid_o || araddr_o !== prev_addr)) stable_ok = 0;
            prev_stalled = arvalid_o && !arready_i;
            prev_addr    = araddr_o;
            if (arvalid_o && arready_i) begin
                ar_q.push_back(araddr_o);
                if (arlen_o !== 8'd3) len_ok = 0;
            end
            if (buf_wr_a_o) begin
                if (buf_idx_o !== 2'(wa_cnt)) idx_ok = 0;
                wa_cnt++;
            end
            if (buf_wr_b_o) begin
                if (buf_idx_o !== 2'(wb_cnt)) idx_ok = 0;
                wb_cnt++;
            end
            if (acc_clr_o) acc_cnt++;
            if (mac_en_o) begin
                if (mac_k_o !== 2'(mac_cnt)) k_ok = 0;
                mac_cnt++;
            end
            if (awvalid_o) begin
                aw_addr = awaddr_o; aw_len = awlen_o; aw_cnt++;
            end
            if (wvalid_o) begin
                if (wrow_o !== 2'(w_cnt) || wlast_o !== (w_cnt == 3)) w_ok = 0;
                w_cnt++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; mat_width_i = '0;
        mat_a_addr_i = '0; mat_b_addr_i = '0; mat_c_addr_i = '0;
        arready_i = 1'b1; rvalid_i = 1'b1; awready_i = 1'b1; wready_i = 1'b1; bvalid_i = 1'b1;
        repeat (3) @(negedge clk);
        check_val("reset_outs", all_outs(), '0);
        rst_n = 1'b1;

        // Width 4, zero wait
        run(8'd4, 0, 0, 0, 0);
        check_val("w4_done_cyc", done_cyc, 25);
        check_val("w4_c1_busy_arv_clr", c1_flags, 3'b111);
        check_val("w4_ar_count", ar_q.size(), 2);
        if (ar_q.size() == 2) begin
            check_val("w4_ar0", ar_q[0], 32'h0);
            check_val("w4_ar1", ar_q[1], 32'h1000);
        end
        check_val("w4_arlen", len_ok, 1);
        check_val("w4_mac_cnt", mac_cnt, 4);
        check_val("w4_mac_k", k_ok, 1);
        check_val("w4_buf_a", wa_cnt, 4);
        check_val("w4_buf_b", wb_cnt, 4);
        check_val("w4_buf_idx", idx_ok, 1);
        check_val("w4_awaddr", aw_addr, 32'h2000);
        check_val("w4_awlen", aw_len, 8'd3);
        check_val("w4_aw_cycles", aw_cnt, 1);
        check_val("w4_w_rows", w_cnt, 4);
        check_val("w4_w_order_last", w_ok, 1);
        check_val("w4_done_stays", done_o, 1);

        // Width 16, back-to-back: done drops the cycle after the new start
        run(8'd16, 0, 0, 0, 0);
        check_val("w16_done_cleared_c1", done_c1, 0);
        check_val("w16_done_cyc", done_cyc, 67);
        check_val("w16_ar_count", ar_q.size(), 8);
        for (int i = 0; i < 8 && i < ar_q.size(); i++)
            check_val($sformatf("w16_ar%0d", i), ar_q[i],
                      ((i % 2) ? 32'h1000 : 32'h0) + 32'(i / 2) * 32'd64);
        check_val("w16_mac_cnt", mac_cnt, 16);
        check_val("w16_mac_k", k_ok, 1);

        // arready held low 3 cycles on the first AR
        run(8'd4, 3, 0, 0, 0);
        check_val("stall_done_cyc", done_cyc, 28);
        check_val("stall_ar_stable", stable_ok, 1);
        check_val("stall_ar0", (ar_q.size() > 0) ? ar_q[0] : 32'hffff_ffff, 32'h0);

        // rvalid toggling
        run(8'd8, 0, 1, 0, 0);
        check_val("tog_completed", done_cyc > 0, 1);
        check_val("tog_buf_a", wa_cnt, 8);
        check_val("tog_buf_b", wb_cnt, 8);
        check_val("tog_buf_idx", idx_ok, 1);

        // Width 2 floors to zero chunks
        run(8'd2, 0, 0, 0, 0);
        check_val("w2_done_cyc", done_cyc, 11);
        check_val("w2_no_ar", ar_q.size(), 0);
        check_val("w2_acc_clr", acc_cnt, 1);
        check_val("w2_mac_cnt", mac_cnt, 0);
        check_val("w2_awaddr", aw_addr, 32'h2000);
        check_val("w2_w_rows", w_cnt, 4);

        // start and config change while busy are ignored
        run(8'd4, 0, 0, 1, 0);
        check_val("poke_done_cyc", done_cyc, 25);
        check_val("poke_ar_count", ar_q.size(), 2);
        if (ar_q.size() == 2) begin
            check_val("poke_ar0", ar_q[0], 32'h0);
            check_val("poke_ar1", ar_q[1], 32'h1000);
        end
        check_val("poke_awaddr", aw_addr, 32'h2000);

        // Reset for one cycle during R_B, then a normal run
        run(8'd4, 0, 0, 0, 8);
        run(8'd4, 0, 0, 0, 0);
        check_val("post_rst_done_cyc", done_cyc, 25);
        check_val("post_rst_mac_cnt", mac_cnt, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
